// File: rtl/bus_main_arbiter_pkg.sv
// ============================================================================
// bus_main_arbiter_pkg : shared types for the main-bus arbiter family
// Revision: 1.0
// ============================================================================
`default_nettype none

package bus_main_arbiter_pkg;

  typedef struct packed {
    logic idle;
    logic xfer;
    logic err;
  } bmain_state_t;

  localparam bmain_state_t ST_IDLE = 3'b100;
  localparam bmain_state_t ST_XFER = 3'b010;
  localparam bmain_state_t ST_ERR  = 3'b001;

  localparam logic BUS_CMD_WRITE = 1'b0;
  localparam logic BUS_CMD_READ  = 1'b1;

  typedef enum logic [1:0] {
    ECAUSE_NONE     = 2'd0,
    ECAUSE_BUS_FE1  = 2'd1,
    ECAUSE_BUS_MEM1 = 2'd2
  } ecause_t;

endpackage

`default_nettype wire

// File: rtl/bus_main_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-request round-robin picker; on a tie the non-last requester wins
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bus_main_arbiter.sv
// ============================================================================
// bus_main_arbiter : fe1/mem1 to main-bus slave arbiter, round-robin, grant
//                    held for a whole transaction including error handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_main_arbiter
  import bus_main_arbiter_pkg::*;
#(
  parameter int AW = 27,
  parameter int DW = 32
) (
  input  logic            clk_core,
  input  logic            reset_n,
  input  logic            fe1_cvalid,
  input  logic            mem1_cvalid,
  input  logic            fe1_cmd,
  input  logic            mem1_cmd,
  input  logic [AW-1:0]   fe1_bus_addr,
  input  logic [AW-1:0]   mem1_bus_addr,
  input  logic            fe1_wvalid,
  input  logic            mem1_wvalid,
  input  logic            fe1_wlast,
  input  logic            mem1_wlast,
  input  logic [DW-1:0]   fe1_bus_wdata,
  input  logic [DW-1:0]   mem1_bus_wdata,
  input  logic [DW/8-1:0] fe1_wmask,
  input  logic [DW/8-1:0] mem1_wmask,
  input  logic            fe1_rready,
  input  logic            mem1_rready,
  input  logic            fe1_eack,
  input  logic            mem1_eack,
  output logic            bmain_cready_fe1,
  output logic            bmain_cready_mem1,
  output logic            bmain_wready_fe1,
  output logic            bmain_wready_mem1,
  output logic            bmain_rvalid_fe1,
  output logic            bmain_rvalid_mem1,
  output logic            bmain_error_fe1,
  output logic            bmain_error_mem1,
  output logic            bmain_rlast,
  output logic [DW-1:0]   bmain_rdata,
  output logic            bus_cvalid,
  output logic            bus_cmd,
  output logic [AW-1:0]   bus_addr,
  input  logic            bus_cready,
  output logic            bus_wvalid,
  output logic            bus_wlast,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_wmask,
  input  logic            bus_wready,
  input  logic            bus_rvalid,
  input  logic            bus_rlast,
  input  logic [DW-1:0]   bus_rdata,
  output logic            bus_rready,
  input  logic            bus_error,
  output logic            bus_eack
);

  bmain_state_t state;
  logic         owner;
  logic         last;
  logic         cmd_done;
  logic         wdone;

  logic [1:0]      req;
  logic            rr_grant;
  logic            sel;
  logic            active;
  logic            m_cvalid, m_cmd, m_wvalid, m_wlast, m_rready, m_eack;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wmask;
  logic            cmd_open, w_open, r_open;
  logic            c_hs, w_hs, wlast_hs, rlast_hs;
  logic            lock_now, busy, cd_next, wd_next, complete;
  logic            rv_any, err_any;

  assign req = {mem1_cvalid | mem1_wvalid, fe1_cvalid | fe1_wvalid};

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last),
    .grant (rr_grant)
  );

  // Before lock the picker decides each cycle; once locked the owner is held.
  assign sel    = state.idle ? rr_grant : owner;
  assign active = reset_n & (state.idle ? (|req) : 1'b1);

  assign m_cvalid = sel ? mem1_cvalid    : fe1_cvalid;
  assign m_cmd    = sel ? mem1_cmd       : fe1_cmd;
  assign m_addr   = sel ? mem1_bus_addr  : fe1_bus_addr;
  assign m_wvalid = sel ? mem1_wvalid    : fe1_wvalid;
  assign m_wlast  = sel ? mem1_wlast     : fe1_wlast;
  assign m_wdata  = sel ? mem1_bus_wdata : fe1_bus_wdata;
  assign m_wmask  = sel ? mem1_wmask     : fe1_wmask;
  assign m_rready = sel ? mem1_rready    : fe1_rready;
  assign m_eack   = sel ? mem1_eack      : fe1_eack;

  // A channel closes once its part of the transaction is done, or on error.
  assign cmd_open = active & ~state.err & ~cmd_done;
  assign w_open   = active & ~state.err & ~wdone;
  assign r_open   = active & ~state.err;

  assign bus_cvalid = cmd_open & m_cvalid;
  assign bus_cmd    = active & m_cmd;
  assign bus_addr   = active ? m_addr : '0;
  assign bus_wvalid = w_open & m_wvalid;
  assign bus_wlast  = w_open & m_wlast;
  assign bus_wdata  = active ? m_wdata : '0;
  assign bus_wmask  = active ? m_wmask : '0;
  assign bus_rready = r_open & m_rready;
  assign bus_eack   = active & m_eack;

  assign c_hs     = bus_cvalid & bus_cready;
  assign w_hs     = bus_wvalid & bus_wready;
  assign wlast_hs = w_hs & m_wlast;
  assign rlast_hs = bus_rready & bus_rvalid & bus_rlast;

  assign lock_now = state.idle & active & (c_hs | w_hs);
  assign busy     = state.xfer | lock_now;
  assign cd_next  = cmd_done | c_hs;
  assign wd_next  = wdone | wlast_hs;
  assign complete = (m_cmd == BUS_CMD_WRITE) ? (cd_next & wd_next) : rlast_hs;

  assign rv_any  = r_open & bus_rvalid;
  assign err_any = reset_n & bus_error & (state.xfer | state.err | lock_now);

  assign bmain_cready_fe1  = c_hs & ~sel;
  assign bmain_cready_mem1 = c_hs & sel;
  assign bmain_wready_fe1  = w_hs & ~sel;
  assign bmain_wready_mem1 = w_hs & sel;
  assign bmain_rvalid_fe1  = rv_any & ~sel;
  assign bmain_rvalid_mem1 = rv_any & sel;
  assign bmain_error_fe1   = err_any & ~sel;
  assign bmain_error_mem1  = err_any & sel;
  assign bmain_rdata       = bus_rdata;
  assign bmain_rlast       = bus_rlast;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      last     <= 1'b0;
      cmd_done <= 1'b0;
      wdone    <= 1'b0;
    end else if (state.err) begin
      if (bus_error && m_eack) begin
        state <= ST_IDLE;
        last  <= owner;
      end
    end else if (busy) begin
      owner <= sel;
      if (bus_error) begin
        cmd_done <= 1'b0;
        wdone    <= 1'b0;
        if (m_eack) begin
          state <= ST_IDLE;
          last  <= sel;
        end else begin
          state <= ST_ERR;
        end
      end else if (complete) begin
        state    <= ST_IDLE;
        last     <= sel;
        cmd_done <= 1'b0;
        wdone    <= 1'b0;
      end else begin
        state    <= ST_XFER;
        cmd_done <= cd_next;
        wdone    <= wd_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_main_arbiter.sv
// ============================================================================
// tb_bus_main_arbiter : directed scenarios plus randomized transactions
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_main_arbiter;

  localparam int AW = 27;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [1:0]    cv, cmd, wv, wl, rr, ea;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wd [2];
  logic [3:0]    wm [2];
  logic [1:0]    crdy, wrdy, rv, er;
  logic          bmain_rlast, bus_cvalid, bus_cmd, bus_wvalid, bus_wlast, bus_rready, bus_eack;
  logic [DW-1:0] bmain_rdata, bus_wdata, bus_rdata;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_wmask;
  logic          bus_cready, bus_wready, bus_rvalid, bus_rlast, bus_error;

  int checks = 0;
  int errors = 0;
  int mlast;
  bit pend [2];
  int pb [2];

  logic [12:0] outs;
  assign outs = {bus_cvalid, bus_cmd, |bus_addr, bus_wvalid, bus_wlast, |bus_wdata, |bus_wmask,
                 bus_rready, bus_eack, |crdy, |wrdy, |rv, |er};

  bus_main_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_core(clk), .reset_n(reset_n),
    .fe1_cvalid(cv[0]), .mem1_cvalid(cv[1]), .fe1_cmd(cmd[0]), .mem1_cmd(cmd[1]),
    .fe1_bus_addr(addr[0]), .mem1_bus_addr(addr[1]),
    .fe1_wvalid(wv[0]), .mem1_wvalid(wv[1]), .fe1_wlast(wl[0]), .mem1_wlast(wl[1]),
    .fe1_bus_wdata(wd[0]), .mem1_bus_wdata(wd[1]), .fe1_wmask(wm[0]), .mem1_wmask(wm[1]),
    .fe1_rready(rr[0]), .mem1_rready(rr[1]), .fe1_eack(ea[0]), .mem1_eack(ea[1]),
    .bmain_cready_fe1(crdy[0]), .bmain_cready_mem1(crdy[1]),
    .bmain_wready_fe1(wrdy[0]), .bmain_wready_mem1(wrdy[1]),
    .bmain_rvalid_fe1(rv[0]), .bmain_rvalid_mem1(rv[1]),
    .bmain_error_fe1(er[0]), .bmain_error_mem1(er[1]),
    .bmain_rlast(bmain_rlast), .bmain_rdata(bmain_rdata),
    .bus_cvalid(bus_cvalid), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_cready(bus_cready),
    .bus_wvalid(bus_wvalid), .bus_wlast(bus_wlast), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_wready(bus_wready), .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast), .bus_rdata(bus_rdata),
    .bus_rready(bus_rready), .bus_error(bus_error), .bus_eack(bus_eack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    cv = '0; cmd = '0; wv = '0; wl = '0; rr = '0; ea = '0;
    for (int m = 0; m < 2; m++) begin
      addr[m] = '0; wd[m] = '0; wm[m] = '0;
    end
    bus_cready = 0; bus_wready = 0; bus_rvalid = 0; bus_rlast = 0; bus_rdata = '0; bus_error = 0;
  endtask

  task automatic pulse_reset;
    @(negedge clk); reset_n = 0;
    @(negedge clk); reset_n = 1;
    mlast = 0;
    tick();
  endtask

  task automatic test_reset;
    idle_all();
    reset_n = 0;
    cv[0] = 1; cmd[0] = 1; addr[0] = 27'h123;
    #1;
    checks++; if (outs !== '0) $display("FAIL reset_outputs: got %b expected 0", outs);
    if (outs !== '0) errors++;
    @(negedge clk); reset_n = 1; cv[0] = 0; addr[0] = '0; cmd[0] = 0;
    mlast = 0;
    tick();
    bus_rvalid = 1; bus_error = 1; ea = 2'b11;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL idle_stray_slave: got %b expected 0", outs);
    end
    idle_all();
  endtask

  task automatic test_fe1_read;
    cv[0] = 1; cmd[0] = 1; addr[0] = 27'h100; rr[0] = 1; bus_cready = 1;
    #1;
    checks++;
    if ({bus_cvalid, bus_cmd, bus_addr, crdy} !== {1'b1, 1'b1, 27'h100, 2'b01}) begin
      errors++; $display("FAIL fe1_read_cmd: got %b %b %h %b expected 1 1 100 01", bus_cvalid, bus_cmd, bus_addr, crdy);
    end
    tick();
    cv[0] = 0; bus_cready = 0;
    for (int i = 0; i < 4; i++) begin
      bus_rvalid = 1; bus_rdata = 32'hA0 + i; bus_rlast = (i == 3);
      #1;
      checks++;
      if (rv !== 2'b01 || bmain_rdata !== 32'hA0 + i || bmain_rlast !== (i == 3)) begin
        errors++; $display("FAIL fe1_read_beat%0d: got rv=%b data=%h expected rv=01 data=%h", i, rv, bmain_rdata, 32'hA0 + i);
      end
      tick();
    end
    bus_rvalid = 0; bus_rlast = 0; rr[0] = 0;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL fe1_read_idle: got %b expected 0", outs);
    end
    mlast = 0;
    idle_all();
  endtask

  task automatic test_tie;
    pulse_reset();
    cv = 2'b11; cmd = 2'b11; addr[0] = 27'h200; addr[1] = 27'h300; rr = 2'b11; bus_cready = 1;
    #1;
    checks++;
    if (crdy !== 2'b10 || bus_addr !== 27'h300) begin
      errors++; $display("FAIL tie_first_grant: got crdy=%b addr=%h expected 10 300", crdy, bus_addr);
    end
    tick();
    cv[1] = 0;
    #1;
    checks++;
    if (crdy !== 2'b00 || bus_cvalid !== 1'b0) begin
      errors++; $display("FAIL tie_fe1_waits: got crdy=%b cvalid=%b expected 00 0", crdy, bus_cvalid);
    end
    bus_rvalid = 1; bus_rlast = 1; bus_rdata = 32'h55;
    #1;
    checks++;
    if (rv !== 2'b10) begin
      errors++; $display("FAIL tie_mem1_data: got %b expected 10", rv);
    end
    tick();
    bus_rvalid = 0; bus_rlast = 0;
    #1;
    checks++;
    if (crdy !== 2'b01 || bus_addr !== 27'h200) begin
      errors++; $display("FAIL tie_fe1_next: got crdy=%b addr=%h expected 01 200", crdy, bus_addr);
    end
    tick();
    cv[0] = 0; bus_rvalid = 1; bus_rlast = 1;
    #1;
    checks++;
    if (rv !== 2'b01) begin
      errors++; $display("FAIL tie_fe1_data: got %b expected 01", rv);
    end
    tick();
    mlast = 0;
    idle_all();
  endtask

  task automatic test_write;
    logic [DW-1:0] exp;
    cv[1] = 1; wv[1] = 1; cmd[1] = 0; addr[1] = 27'h40; wm[1] = 4'hF; bus_wready = 1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'h11 * (i + 1);
      wd[1] = exp; wl[1] = (i == 3); bus_cready = (i == 3);
      if (i == 1) begin cv[0] = 1; cmd[0] = 1; addr[0] = 27'h500; end
      #1;
      checks++;
      if (wrdy !== 2'b10 || bus_wdata !== exp || bus_wlast !== (i == 3) || bus_addr !== 27'h40 ||
          crdy !== ((i == 3) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL write_beat%0d: got wrdy=%b data=%h crdy=%b addr=%h expected 10 %h %b 40",
                           i, wrdy, bus_wdata, crdy, bus_addr, exp, (i == 3) ? 2'b10 : 2'b00);
      end
      tick();
    end
    cv[1] = 0; wv[1] = 0; wl[1] = 0; bus_cready = 1;
    #1;
    checks++;
    if (crdy !== 2'b01 || bus_addr !== 27'h500) begin
      errors++; $display("FAIL write_then_fe1: got crdy=%b addr=%h expected 01 500", crdy, bus_addr);
    end
    tick();
    cv[0] = 0; rr[0] = 1; bus_rvalid = 1; bus_rlast = 1;
    tick();
    mlast = 0;
    idle_all();
  endtask

  task automatic test_error;
    cv[1] = 1; cmd[1] = 1; addr[1] = 27'h80; rr[1] = 1; bus_cready = 1;
    tick();
    cv[1] = 0; bus_rvalid = 1;
    #1;
    checks++;
    if (rv !== 2'b10) begin errors++; $display("FAIL err_beat1: got %b expected 10", rv); end
    tick();
    bus_rvalid = 0; bus_error = 1; ea[1] = 1;
    #1;
    checks++;
    if (er !== 2'b10 || bus_eack !== 1'b1) begin
      errors++; $display("FAIL err_flag: got er=%b eack=%b expected 10 1", er, bus_eack);
    end
    tick();
    bus_error = 0; ea[1] = 0; bus_rvalid = 1;
    #1;
    checks++;
    if (rv !== 2'b00 || er !== 2'b00) begin
      errors++; $display("FAIL err_after: got rv=%b er=%b expected 00 00", rv, er);
    end
    bus_rvalid = 0;
    cv[1] = 1;
    tick();
    cv[1] = 0; bus_error = 1;
    #1;
    checks++;
    if (er !== 2'b10 || bus_eack !== 1'b0) begin
      errors++; $display("FAIL err_hold_flag: got er=%b eack=%b expected 10 0", er, bus_eack);
    end
    tick();
    bus_rvalid = 1;
    #1;
    checks++;
    if (rv !== 2'b00 || bus_rready !== 1'b0 || er !== 2'b10) begin
      errors++; $display("FAIL err_hold_block: got rv=%b rready=%b er=%b expected 00 0 10", rv, bus_rready, er);
    end
    ea[1] = 1;
    #1;
    checks++;
    if (bus_eack !== 1'b1) begin errors++; $display("FAIL err_eack: got %b expected 1", bus_eack); end
    tick();
    bus_error = 0; ea[1] = 0; bus_rvalid = 0;
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL err_idle: got %b expected 0", outs); end
    mlast = 1;
    idle_all();
  endtask

  task automatic test_reset_mid;
    cv[0] = 1; wv[0] = 1; cmd[0] = 0; addr[0] = 27'h600; wd[0] = 32'h1; wm[0] = 4'hF;
    bus_cready = 1; bus_wready = 1;
    #1;
    checks++;
    if (crdy !== 2'b01 || wrdy !== 2'b01) begin
      errors++; $display("FAIL rstmid_first: got crdy=%b wrdy=%b expected 01 01", crdy, wrdy);
    end
    tick();
    cv[0] = 0; wd[0] = 32'h2; bus_cready = 0;
    #1;
    reset_n = 0;
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rstmid_async: got %b expected 0", outs); end
    @(negedge clk);
    reset_n = 1; wv[0] = 0; mlast = 0;
    cv[1] = 1; cmd[1] = 1; addr[1] = 27'h700; bus_cready = 1; bus_wready = 0;
    #1;
    checks++;
    if (crdy !== 2'b10 || bus_addr !== 27'h700) begin
      errors++; $display("FAIL rstmid_regrant: got crdy=%b addr=%h expected 10 700", crdy, bus_addr);
    end
    tick();
    cv[1] = 0; rr[1] = 1; bus_rvalid = 1; bus_rlast = 1;
    tick();
    mlast = 1;
    idle_all();
  endtask

  task automatic new_req(input int m);
    pend[m] = 1;
    cv[m]   = 1;
    cmd[m]  = 1'($urandom_range(0, 1));
    addr[m] = AW'($urandom);
    pb[m]   = $urandom_range(1, 4);
    wv[m]   = (cmd[m] == 1'b0);
    wd[m]   = $urandom;
    wm[m]   = 4'($urandom);
    wl[m]   = (cmd[m] == 1'b0) && (pb[m] == 1);
  endtask

  task automatic run_xfer(input int m);
    int o = 1 - m;
    int beat = 0;
    int cyc = 0;
    bit cacc = 0;
    bit done = 0;
    bit c_hs, w_hs, r_hs;
    while (!done && cyc < 200) begin
      bus_cready = 1'($urandom_range(0, 1));
      bus_wready = 1'($urandom_range(0, 1));
      rr[m] = ($urandom_range(0, 3) != 0);
      if (cmd[m] == 1'b1 && cacc && !bus_rvalid) begin
        bus_rvalid = 1'($urandom_range(0, 1));
        bus_rdata  = $urandom;
        bus_rlast  = (beat == pb[m] - 1);
      end
      #1;
      checks++;
      if (crdy[o] !== 1'b0 || wrdy[o] !== 1'b0 || rv[o] !== 1'b0 || er[o] !== 1'b0) begin
        errors++; $display("FAIL rnd_other%0d: got c%b w%b r%b e%b expected all 0", o, crdy[o], wrdy[o], rv[o], er[o]);
      end
      checks++;
      if (crdy[m] !== (cv[m] & bus_cready) || (cv[m] && (bus_addr !== addr[m] || bus_cmd !== cmd[m]))) begin
        errors++; $display("FAIL rnd_cmd%0d: got crdy=%b addr=%h expected %b %h", m, crdy[m], bus_addr, cv[m] & bus_cready, addr[m]);
      end
      checks++;
      if (cmd[m] == 1'b0) begin
        if (wrdy[m] !== (wv[m] & bus_wready) ||
            (wv[m] && (bus_wdata !== wd[m] || bus_wlast !== wl[m] || bus_wmask !== wm[m]))) begin
          errors++; $display("FAIL rnd_wr%0d: got wrdy=%b data=%h last=%b expected %b %h %b",
                             m, wrdy[m], bus_wdata, bus_wlast, wv[m] & bus_wready, wd[m], wl[m]);
        end
      end else if (rv[m] !== bus_rvalid || bus_rready !== rr[m] || (bus_rvalid && bmain_rdata !== bus_rdata)) begin
        errors++; $display("FAIL rnd_rd%0d: got rv=%b rready=%b expected %b %b", m, rv[m], bus_rready, bus_rvalid, rr[m]);
      end
      c_hs = cv[m] & bus_cready;
      w_hs = wv[m] & bus_wready;
      r_hs = bus_rvalid & rr[m];
      tick();
      cyc++;
      if (c_hs) begin cv[m] = 0; cacc = 1; end
      if (cmd[m] == 1'b0) begin
        if (w_hs) begin
          beat++;
          if (beat == pb[m]) begin wv[m] = 0; wl[m] = 0; end
          else begin wd[m] = $urandom; wl[m] = (beat == pb[m] - 1); end
        end
        done = cacc && (beat == pb[m]);
      end else if (r_hs) begin
        beat++;
        bus_rvalid = 0; bus_rlast = 0;
        done = (beat == pb[m]);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL rnd_timeout%0d: got %0d beats expected %0d", m, beat, pb[m]);
      $fatal(1, "transaction stalled");
    end
    bus_cready = 0; bus_wready = 0; rr[m] = 0;
  endtask

  task automatic test_traffic(input int n, input bit both);
    int win;
    int t = 0;
    pend[0] = 0; pend[1] = 0;
    while (t < n || pend[0] || pend[1]) begin
      if (t < n) begin
        for (int m = 0; m < 2; m++)
          if (!pend[m] && (both || $urandom_range(0, 1) == 1)) new_req(m);
        if (!pend[0] && !pend[1]) new_req($urandom_range(0, 1));
      end
      if (pend[0] && pend[1]) win = (mlast == 0) ? 1 : 0;
      else win = pend[1] ? 1 : 0;
      run_xfer(win);
      pend[win] = 0;
      mlast = win;
      t++;
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_fe1_read();
    test_tie();
    test_write();
    test_error();
    test_reset_mid();
    test_traffic(6, 1'b1);
    test_traffic(40, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_main_arbiter.md
Name: bus_main_arbiter

Overview:
Two-master to one-slave arbiter for the main memory bus. It shares the slave between fetch1 (icache fill, prefix fe1) and memory1 (dcache evict/fill and PTE traffic, prefix mem1). It produces the bmain_*_fe1 / bmain_*_mem1 return signals those stages consume. Grants use round-robin and are held for a whole transaction, including the error/ack handshake.

Parameters:
AW, 27, bus word-address width (address bits 28:2)
DW, 32, data width; mask width is DW/8

Ports:
clk_core  in  1  core clock
reset_n  in  1  asynchronous active-low reset
fe1_cvalid, mem1_cvalid  in  1  command valid per master
fe1_cmd, mem1_cmd  in  1  0=write, 1=read
fe1_bus_addr, mem1_bus_addr  in  AW  word address
fe1_wvalid, mem1_wvalid  in  1  write beat valid
fe1_wlast, mem1_wlast  in  1  last write beat
fe1_bus_wdata, mem1_bus_wdata  in  DW  write data
fe1_wmask, mem1_wmask  in  DW/8  byte mask
fe1_rready, mem1_rready  in  1  read beat ready
fe1_eack, mem1_eack  in  1  error acknowledge
bmain_cready_fe1, bmain_cready_mem1  out  1  command accepted
bmain_wready_fe1, bmain_wready_mem1  out  1  write beat accepted
bmain_rvalid_fe1, bmain_rvalid_mem1  out  1  read beat valid
bmain_error_fe1, bmain_error_mem1  out  1  transaction error
bmain_rlast  out  1  last read beat (broadcast)
bmain_rdata  out  DW  read data (broadcast)
bus_cvalid, bus_cmd, bus_addr  out  1/1/AW  slave command channel
bus_cready  in  1  slave command ready
bus_wvalid, bus_wlast, bus_wdata, bus_wmask  out  1/1/DW/DW/8  slave write channel
bus_wready  in  1  slave write ready
bus_rvalid, bus_rlast, bus_rdata  in  1/1/DW  slave read channel
bus_rready  out  1  slave read ready
bus_error  in  1  slave error, held until bus_eack
bus_eack  out  1  error acknowledge to slave

Behaviour:
- Interconnect is fully combinational; the only state is the arbiter registers. There is no added latency on any channel.
- Registers: state {IDLE, XFER, ERR} (one-hot struct), owner (0=fe1, 1=mem1), last (owner of the last completed transaction), cmd_done, wdone.
- Reset values: state=IDLE, owner=0, last=0 (mem1 wins the first tie), cmd_done=0, wdone=0.
- IDLE candidate selection:
  - Only one cvalid or wvalid asserted -> that master is the candidate.
  - Both asserted -> the master that is not `last`.
  - Neither -> no candidate; all slave-side outputs are 0.
- Only the candidate/owner's channels are forwarded: c/w outputs, bus_rready, and eack. The non-owner always sees cready=wready=rvalid=error=0.
- bmain_rdata and bmain_rlast are always driven from bus_rdata and bus_rlast. They are meaningful only with the qualifying rvalid.
- Lock: IDLE moves to XFER with owner=candidate on the first cycle any c or w handshake of the candidate completes. cmd_done and wdone capture handshakes that occurred in that cycle.
  - Before lock, the candidate may change between cycles.
- Completion rules:
  - Write (cmd=0): complete when cmd_done and the wlast beat has been accepted (either may come first).
  - Read (cmd=1): complete on bus_rvalid & rready & bus_rlast.
  - On completion: state -> IDLE, last=owner, flags cleared.
  - A write finishing entirely in the locking cycle returns directly to IDLE.
- Error:
  - bus_error while locked (or in the locking cycle) -> bmain_error_<owner>=1 and state -> ERR.
  - bus_eack = <owner>_eack, combinationally.
  - Leave ERR for IDLE on the cycle bus_error & eack, with last=owner.
  - Remaining write beats and read beats are abandoned: wready and rvalid are forced to 0 in ERR.
- bus_error in IDLE with no candidate: ignored, bus_eack=0 (slave protocol violation; bench flags it).
- Reset asserted mid-transaction: all registers return to reset values immediately and outputs drop to 0. The slave is reset from the same reset_n.
- A master must not deassert cvalid/wvalid before its handshake. The arbiter does not check this.

Decomposition:
- Shared package: bmain_state_t (packed one-hot struct idle/xfer/err) and the BUS_CMD_WRITE=0 / BUS_CMD_READ=1 constants, next to ecause_t in defines.
- Sub-module rr_arb2 (two-request round-robin picker: req[1:0], last, grant). It is reused by any later two-master arbiter.

Test Plan:
- fe1 read alone, addr 0x0000100, slave returns 4 beats 0xA0..0xA3 with rlast on the 4th -> bmain_rvalid_fe1 pulses 4 times; mem1 sees nothing; IDLE after the rlast cycle; last=fe1.
- Both cvalid in the same cycle after reset -> mem1 granted first. Once it completes, the pending fe1 request is granted in the next cycle.
- mem1 write, cvalid+wvalid in the same cycle, bus_cready delayed 3 cycles while wready=1, 4 beats of data 0x11..0x44 -> 4 beats pass through in order. IDLE only after both the cready and wlast handshakes.
- mem1 read, bus_error asserted on beat 2 with mem1_eack in the same cycle -> bmain_error_mem1=1 for exactly that cycle; bus_eack=1; no further rvalid; IDLE next cycle.
- reset_n pulsed low mid fe1 write beat 2 -> all outputs 0 asynchronously; after release, a new mem1 read is granted immediately.
- Back-to-back fe1 requests with mem1 continuously requesting -> grants alternate fe1, mem1, fe1 (no starvation).
